decode_lut_pipe: RTL and testbench

// - Programmable, pipelined instruction-decode table: maps a compressed inst key {func7,func3,opcode[6:2]} to a micro command.
// - Entries hold pattern + care-mask + micro; lowest matching index wins, replacing wired-OR hit merging.
// - Sits between IFU and EXU: valid/ready in, one registered output stage, illegal-inst flag on miss.

---
 rtl/decode_lut_pipe.sv | 124 ++++++++++++
 tb/tb_decode_lut_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_lut_pipe.sv
// Programmable decode table: masked key match, lowest index wins, one output register.
// Define DECODE_LUT_MULTIHIT_EN to add the multi_hit output flag.
module decode_lut_pipe #(
  parameter int PATTERN_LEN = 15,
  parameter int MICRO_LEN   = 13,
  parameter int ENTRY_NR    = 32,
  parameter int IDX_W       = $clog2(ENTRY_NR),
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic                   wr_valid,
  input  logic [PATTERN_LEN-1:0] wr_pattern,
  input  logic [PATTERN_LEN-1:0] wr_mask,
  input  logic [MICRO_LEN-1:0]   wr_micro,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PATTERN_LEN-1:0] in_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MICRO_LEN-1:0]   out_micro,
  output logic                   out_hit,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_illegal,
  output logic [CNT_W-1:0]       miss_cnt
`ifdef DECODE_LUT_MULTIHIT_EN
  ,
  output logic                   multi_hit
`endif
);

  logic [ENTRY_NR-1:0]    ent_v;
  logic [PATTERN_LEN-1:0] ent_pat [ENTRY_NR];
  logic [PATTERN_LEN-1:0] ent_msk [ENTRY_NR];
  logic [MICRO_LEN-1:0]   ent_mic [ENTRY_NR];

  logic [ENTRY_NR-1:0]    match;
  logic                   hit;
  logic [IDX_W-1:0]       hidx;
  logic [MICRO_LEN-1:0]   hmic;
  logic                   acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_v <= '0;
    end else if (wr_en) begin
      ent_v[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ent_pat[wr_idx] <= wr_pattern;
      ent_msk[wr_idx] <= wr_mask;
      ent_mic[wr_idx] <= wr_micro;
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < ENTRY_NR; i++) begin
      match[i] = ent_v[i] &
        ~|((in_inst ^ ent_pat[i]) & ent_msk[i]);
    end
  end

  // Scan downward so the lowest matching index is the last one kept.
  always_comb begin
    hit  = 1'b0;
    hidx = '0;
    for (int i = ENTRY_NR - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit  = 1'b1;
        hidx = i[IDX_W-1:0];
      end
    end
  end

  assign hmic     = hit ? ent_mic[hidx] : '0;
  assign in_ready = !out_valid | out_ready;
  assign acc      = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_micro   <= '0;
      out_hit     <= 1'b0;
      out_idx     <= '0;
      out_illegal <= 1'b0;
      miss_cnt    <= '0;
    end else if (acc) begin
      out_valid   <= 1'b1;
      out_micro   <= hmic;
      out_hit     <= hit;
      out_idx     <= hidx;
      out_illegal <= !hit;
      if (!hit && miss_cnt != '1) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end else if (out_ready) begin
      out_valid   <= 1'b0;
      out_illegal <= 1'b0;
    end
  end

`ifdef DECODE_LUT_MULTIHIT_EN
  logic mh;
  assign mh = |(match & (match - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      multi_hit <= 1'b0;
    end else if (acc) begin
      multi_hit <= mh;
      if (mh) begin
        $error("decode_lut_pipe: multiple entries hit key %h", in_inst);
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_lut_pipe.sv
// Scoreboard bench for decode_lut_pipe: directed cases then random traffic.
module tb_decode_lut_pipe;

  logic        clk = 0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic        wr_valid;
  logic [14:0] wr_pattern;
  logic [14:0] wr_mask;
  logic [12:0] wr_micro;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_micro;
  logic        out_hit;
  logic [4:0]  out_idx;
  logic        out_illegal;
  logic [31:0] miss_cnt;

  decode_lut_pipe dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
    .wr_pattern(wr_pattern), .wr_mask(wr_mask), .wr_micro(wr_micro),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_micro(out_micro), .out_hit(out_hit), .out_idx(out_idx),
    .out_illegal(out_illegal), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] micro;
    logic        hit;
    logic [4:0]  idx;
    logic [31:0] miss;
  } exp_t;

  exp_t q[$];

  // Reference table and pipeline occupancy
  bit          mv [32];
  logic [14:0] mp [32];
  logic [14:0] mm [32];
  logic [12:0] mmi[32];
  bit          mvalid;
  logic [31:0] mmiss;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic exp_t lookup(logic [14:0] k);
    exp_t e;
    e.micro = '0; e.hit = 0; e.idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (mv[i] && ((k & mm[i]) == (mp[i] & mm[i]))) begin
        e.micro = mmi[i]; e.hit = 1; e.idx = 5'(i);
        break;
      end
    end
    return e;
  endfunction

  task automatic step(input bit iv, input logic [14:0] k,
                      input bit ordy, input bit we = 0,
                      input int widx = 0, input bit wv = 0,
                      input logic [14:0] wp = 0,
                      input logic [14:0] wm = 0,
                      input logic [12:0] wmi = 0);
    exp_t e;
    bit rdy;
    in_valid = iv; in_inst = k; out_ready = ordy;
    wr_en = we; wr_idx = 5'(widx); wr_valid = wv;
    wr_pattern = wp; wr_mask = wm; wr_micro = wmi;
    @(negedge clk);
    rdy = !mvalid || ordy;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, mvalid});
    if (iv && rdy) begin
      e = lookup(k);
      if (!e.hit && mmiss != 32'hFFFF_FFFF) mmiss++;
      e.miss = mmiss;
      q.push_back(e);
      mvalid = 1;
    end else if (ordy) begin
      mvalid = 0;
    end
    if (we) begin
      mv[widx] = wv; mp[widx] = wp; mm[widx] = wm; mmi[widx] = wmi;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 1; wr_en = 0;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    for (int i = 0; i < 32; i++) mv[i] = 0;
    mvalid = 0; mmiss = 0;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_hit", {31'b0, out_hit}, 0);
    chk("rst_out_illegal", {31'b0, out_illegal}, 0);
    chk("rst_out_micro", {19'b0, out_micro}, 0);
    chk("rst_out_idx", {27'b0, out_idx}, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
  endtask

  // Monitor: held output must equal queue head; pop on handshake
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out: got valid result expected none");
      end else begin
        chk("out_hit", {31'b0, out_hit}, {31'b0, q[0].hit});
        chk("out_idx", {27'b0, out_idx}, {27'b0, q[0].idx});
        chk("out_micro", {19'b0, out_micro}, {19'b0, q[0].micro});
        chk("out_illegal", {31'b0, out_illegal},
            {31'b0, !q[0].hit});
        chk("miss_cnt", miss_cnt, q[0].miss);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    mvalid = 0; mmiss = 0;
    in_inst = 0; wr_idx = 0; wr_valid = 0;
    wr_pattern = 0; wr_mask = 0; wr_micro = 0;
    do_reset();

    // LUI hit
    step(0, 0, 1, 1, 0, 1, 15'h000D, 15'h001F, 13'h1006);
    step(1, 15'h7F8D, 1);
    // SUB exact entry, near-miss key
    step(0, 0, 1, 1, 1, 1, 15'h200C, 15'h7FFF, 13'h0A55);
    step(1, 15'h000C, 1);
    // Catch-all at idx2 versus LUI at idx0
    step(0, 0, 1, 1, 2, 1, 15'h0000, 15'h0000, 13'h0001);
    step(1, 15'h000D, 1);
    step(1, 15'h0013, 1);
    step(1, 15'h200C, 1);
    // Backpressure for 3 cycles with in_valid held
    step(1, 15'h000D, 0);
    step(1, 15'h0013, 0);
    step(1, 15'h000D, 0);
    step(1, 15'h0013, 1);
    step(1, 15'h000D, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("drain_bp", q.size(), 0);

    // Reset while a result is held and entries are loaded
    step(1, 15'h000D, 0);
    do_reset();
    step(1, 15'h000D, 1);
    step(0, 0, 1);

    // Invalidate and lookup same index in the same cycle
    step(0, 0, 1, 1, 0, 1, 15'h000D, 15'h001F, 13'h1006);
    step(1, 15'h000D, 1, 1, 0, 0, 15'h000D, 15'h001F, 13'h1006);
    step(1, 15'h000D, 1);
    step(0, 0, 1);
    chk("drain_hz", q.size(), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit we;
      int wi;
      logic [14:0] wm;
      we = ($urandom_range(0, 7) == 0);
      wi = $urandom_range(0, 31);
      wm = 15'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) wm = 0;
      step($urandom_range(0, 3) != 0, 15'($urandom),
           $urandom_range(0, 3) != 0, we, wi,
           $urandom_range(0, 4) != 0, 15'($urandom), wm,
           13'($urandom));
    end
    for (int n = 0; n < 4; n++) step(0, 0, 1);
    chk("drain_rand", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
